arb4_sched: RTL and testbench

ARB4_SCHED -- requirements
Module: arb4_sched

---
 rtl/arb4_sched.sv | 137 +++++++++++++
 tb/tb_arb4_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb4_sched.sv
// arb4_sched: four-requester round-robin arbiter with a bounded tenure.
// A grant is held while its requester keeps req high, up to MAX_HOLD cycles,
// after which ownership rotates to the next active requester. Rotation scans
// from the most recent owner, so requester (last+1) mod 4 gets first claim.
// Ownership is carried as a 2-bit index plus a valid flag. These drive a
// shared 2-to-4 decoder; the one-hot gnt vector is that decode, gated by valid.

module arb4_sched #(
    parameter int unsigned MAX_HOLD = 8  // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic [3:0] gnt,
    output logic [7:0] busy_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Last busy_cnt value of a tenure; at this count the owner must rotate out.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic [1:0] last_q, last_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;

    logic [1:0] win_from_last;
    logic [1:0] win_from_owner;

    // Round-robin pick. Candidates are base+1, base+2, base+3, then base.
    // The loop walks downward, so the nearest set request after base is
    // written last and wins. If only base is requesting, or nothing is,
    // the result stays base; callers check req before using it.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = base;
        for (int k = 3; k >= 1; k--) begin
            cand = base + 2'(k);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    // From IDLE the scan starts after the remembered owner. During a tenure,
    // each handover scans from the current owner. On a release the owner's req
    // is already low, so it drops out of the scan. On a timeout the owner is
    // still requesting; it is checked last and wins only if nobody else asks.
    assign win_from_last  = rr_pick(req, last_q);
    assign win_from_owner = rr_pick(req, gnt_idx_q);

    // State register: async reset leaves the pointer at 3 so requester 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= 2'd0;
            last_q     <= 2'd3;
            busy_cnt_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Next-state logic: grant, hold, release, timeout, and the enable drop.
    always_comb begin
        // NOTE: every target gets a hold default first, so no path through the case can infer a latch.
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_d     = last_q;
        busy_cnt_d = busy_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en && (req != 4'b0000)) begin
                    state_d    = ST_GRANT;
                    gnt_idx_d  = win_from_last;
                    busy_cnt_d = 8'd0;
                end
            end

            ST_GRANT: begin
                if (!en) begin
                    // The enable dropped. Ownership still counts, so the next
                    // arbitration resumes after this owner.
                    state_d    = ST_IDLE;
                    last_d     = gnt_idx_q;
                    busy_cnt_d = 8'd0;
                end else if (!req[gnt_idx_q]) begin
                    // Release takes priority over a timeout that falls on the same
                    // cycle. If anyone else is waiting, hand over with no idle gap.
                    last_d     = gnt_idx_q;
                    busy_cnt_d = 8'd0;
                    if (req != 4'b0000) begin
                        gnt_idx_d = win_from_owner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (busy_cnt_q == HOLD_LAST) begin
                    // The tenure is used up. Rotate out; if no one else is
                    // requesting, the same owner is re-granted with a fresh count.
                    last_d     = gnt_idx_q;
                    gnt_idx_d  = win_from_owner;
                    busy_cnt_d = 8'd0;
                end else begin
                    busy_cnt_d = busy_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt_vld  = (state_q == ST_GRANT);
    assign gnt_idx  = gnt_idx_q;
    assign busy_cnt = busy_cnt_q;
    assign gnt      = gnt_vld ? (4'b0001 << gnt_idx_q) : 4'b0000;

    // Invariants: at most one grant bit set, and the tenure counter stays within range.
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    assert property (@(posedge clk) disable iff (!rst_n) busy_cnt <= HOLD_LAST);

endmodule

// File: tb/tb_arb4_sched.sv
// Testbench for arb4_sched. One instance uses the default MAX_HOLD=8 and a
// second uses MAX_HOLD=1; both share the same stimulus. A behavioural
// reference model pushes the expected outputs into a scoreboard queue on every
// clock edge, and those are popped and compared just after the edge. Directed
// scenarios add hand-derived constant checks on top.

module tb_arb4_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic [1:0] gnt_idx,  gnt_idx_h1;
    logic       gnt_vld,  gnt_vld_h1;
    logic [3:0] gnt,      gnt_h1;
    logic [7:0] busy_cnt, busy_cnt_h1;

    arb4_sched u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .gnt_idx  (gnt_idx),
        .gnt_vld  (gnt_vld),
        .gnt      (gnt),
        .busy_cnt (busy_cnt)
    );

    arb4_sched #(.MAX_HOLD(1)) u_dut_h1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .gnt_idx  (gnt_idx_h1),
        .gnt_vld  (gnt_vld_h1),
        .gnt      (gnt_h1),
        .busy_cnt (busy_cnt_h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one slot per instance (0: hold 8, 1: hold 1).
    logic       m_vld  [2];
    logic [1:0] m_idx  [2];
    logic [1:0] m_last [2];
    int         m_cnt  [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int hold_of(input int d);
        return (d == 0) ? 8 : 1;
    endfunction

    // Return the first requester after 'from', wrapping around to 'from' itself last.
    function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] from);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = 2'((int'(from) + k) % 4);
            if (r[c]) return c;
        end
        return from;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d]  = 1'b0;
            m_idx[d]  = 2'd0;
            m_last[d] = 2'd3;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic model_step(input int d, input logic e, input logic [3:0] r);
        if (!m_vld[d]) begin
            if (e && r != 4'b0000) begin
                m_vld[d] = 1'b1;
                m_idx[d] = rr_next(r, m_last[d]);
                m_cnt[d] = 0;
            end
        end else if (!e) begin
            m_last[d] = m_idx[d];
            m_vld[d]  = 1'b0;
            m_cnt[d]  = 0;
        end else if (!r[m_idx[d]]) begin
            m_last[d] = m_idx[d];
            m_cnt[d]  = 0;
            if (r == 4'b0000) m_vld[d] = 1'b0;
            else              m_idx[d] = rr_next(r, m_last[d]);
        end else if (m_cnt[d] >= hold_of(d) - 1) begin
            m_last[d] = m_idx[d];
            m_idx[d]  = rr_next(r, m_last[d]);
            m_cnt[d]  = 0;
        end else begin
            m_cnt[d]++;
        end
    endtask

    // Pop both instances' expectations and compare; r is the req sampled on this edge.
    task automatic compare(input logic [3:0] r);
        exp_t       x;
        logic       a_vld;
        logic [1:0] a_idx;
        logic [3:0] a_gnt;
        logic [7:0] a_cnt;
        string      p;
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "h8" : "h1";
            check({p, ".sb_avail"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                x     = exp_q.pop_front();
                a_vld = (d == 0) ? gnt_vld  : gnt_vld_h1;
                a_idx = (d == 0) ? gnt_idx  : gnt_idx_h1;
                a_gnt = (d == 0) ? gnt      : gnt_h1;
                a_cnt = (d == 0) ? busy_cnt : busy_cnt_h1;
                check({p, ".vld"}, 32'(a_vld), 32'(x.vld));
                check({p, ".gnt"}, 32'(a_gnt), x.vld ? 32'(4'b0001 << x.idx) : 32'd0);
                check({p, ".busy"}, 32'(a_cnt), 32'(x.cnt));
                if (x.vld) check({p, ".idx"}, 32'(a_idx), 32'(x.idx));
                check({p, ".gnt_req_low"}, 32'(a_gnt & ~r), 32'd0);
            end
        end
    endtask

    // Drive inputs, advance one edge, update the model, then sample 1ns after the edge.
    task automatic step(input logic e, input logic [3:0] r);
        exp_t x;
        en  = e;
        req = r;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            model_step(d, e, r);
            x.vld = m_vld[d];
            x.idx = m_idx[d];
            x.cnt = 8'(m_cnt[d]);
            exp_q.push_back(x);
        end
        #1;
        compare(r);
    endtask

    initial begin
        logic       re;
        logic [3:0] rr;

        rst_n = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        check("rst.vld",  32'(gnt_vld),  32'd0);
        check("rst.gnt",  32'(gnt),      32'd0);
        check("rst.idx",  32'(gnt_idx),  32'd0);
        check("rst.busy", 32'(busy_cnt), 32'd0);
        rst_n = 1'b1;

        // The enable is low while every requester is asking: no grant may appear.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b1111);
            check("en0.gnt", 32'(gnt), 32'd0);
        end

        // Full contention: 8-cycle tenures rotating 0,1,2,3,0; hold-1 rotates every cycle.
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 4'b1111);
            check("rot.idx",    32'(gnt_idx),     32'(((k - 1) / 8) % 4));
            check("rot.gnt",    32'(gnt),         32'(1 << (((k - 1) / 8) % 4)));
            check("rot.busy",   32'(busy_cnt),    32'((k - 1) % 8));
            check("rot.h1.idx", 32'(gnt_idx_h1),  32'((k - 1) % 4));
            check("rot.h1.busy",32'(busy_cnt_h1), 32'd0);
        end
        // Owner 0 is at count 7 and drops its request: release wins, so the arbiter goes idle.
        step(1'b1, 4'b0000);
        check("relto.vld", 32'(gnt_vld), 32'd0);

        // A single 3-cycle request gets a 3-cycle grant, then the arbiter returns to idle.
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 4'b0100);
            check("one.gnt",  32'(gnt),      32'h4);
            check("one.busy", 32'(busy_cnt), 32'(k - 1));
        end
        step(1'b1, 4'b0000);
        check("one.end.vld",  32'(gnt_vld),  32'd0);
        check("one.end.busy", 32'(busy_cnt), 32'd0);

        // Owner 1 releases while 0 and 3 are requesting; 3 is next, with no idle gap.
        step(1'b1, 4'b0010);
        check("ho.own1", 32'(gnt_idx), 32'd1);
        step(1'b1, 4'b1011);
        step(1'b1, 4'b1011);
        step(1'b1, 4'b1001);
        check("ho.gnt",  32'(gnt),      32'h8);
        check("ho.vld",  32'(gnt_vld),  32'd1);
        check("ho.busy", 32'(busy_cnt), 32'd0);

        // A lone requester keeps its grant through timeouts; the count wraps 7 -> 0.
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 4'b0100);
            check("solo.gnt",  32'(gnt),      32'h4);
            check("solo.busy", 32'(busy_cnt), 32'((k - 1) % 8));
        end
        // Release and timeout fall on the same cycle with no other requester: the arbiter must go idle.
        step(1'b1, 4'b0000);
        check("relto2.vld", 32'(gnt_vld), 32'd0);

        // The enable drops mid-tenure.
        step(1'b1, 4'b1111);
        check("endrop.own3", 32'(gnt_idx), 32'd3);
        step(1'b1, 4'b1111);
        step(1'b0, 4'b1111);
        check("endrop.vld",  32'(gnt_vld),  32'd0);
        check("endrop.busy", 32'(busy_cnt), 32'd0);
        step(1'b0, 4'b1111);
        check("endrop.hold", 32'(gnt), 32'd0);
        step(1'b1, 4'b1111);
        check("endrop.resume", 32'(gnt_idx), 32'd0);

        // Move ownership to 2, then pulse reset low between clock edges.
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        check("pre_rst.own2", 32'(gnt_idx), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst.gnt",    32'(gnt),      32'd0);
        check("arst.vld",    32'(gnt_vld),  32'd0);
        check("arst.busy",   32'(busy_cnt), 32'd0);
        check("arst.h1.gnt", 32'(gnt_h1),   32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        step(1'b1, 4'b1111);
        check("arst.first", 32'(gnt), 32'h1);

        // Random traffic, with requests held for a few cycles so tenures build up.
        rr = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            re = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            step(re, rr);
        end

        check("sb.drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
